// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_pkg                                                  |
// | Purpose  : Shared constants for the FIFO family of blocks.           |
// | Contents : TRUE / FALSE flag constants, ONE / ZERO single-bit values.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic ONE   = 1'b1;
    localparam logic ZERO  = 1'b0;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_ram                                                  |
// | Purpose  : WIDTH x 2**DEPTH_IN_BITS storage, one synchronous write   |
// |            port and one asynchronous read port. Contents are never   |
// |            reset.                                                    |
// | Ports    : clk              - clock, write on rising edge            |
// |            we               - write enable                           |
// |            waddr / wdata    - write address / data                   |
// |            raddr / rdata    - read address / combinational data      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH_IN_BITS = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DEPTH_IN_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [DEPTH_IN_BITS-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    localparam int DEPTH = 2 ** DEPTH_IN_BITS;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we == TRUE) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_stat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fifo_stat                                                 |
// | Purpose  : Synchronous FIFO with status flags, sticky error flags,   |
// |            synchronous clear and selectable first-word-fall-through  |
// |            (FWFT=1) or registered read (FWFT=0).                     |
// | Ports    : clk, reset (sync, active-high), clear (sync flush)        |
// |            we, data_w        - write request / data                  |
// |            req_r             - read request                          |
// |            data_r, valid_r   - read data / popped-word strobe        |
// |            full, empty, almost_full, almost_empty - status           |
// |            count             - stored words, 0..DEPTH                |
// |            overflow, underflow - sticky error flags                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fifo_stat
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH_IN_BITS = 4,
    parameter int AFULL_LEVEL   = 12,
    parameter int AEMPTY_LEVEL  = 2,
    parameter int FWFT          = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     we,
    input  logic [WIDTH-1:0]         data_w,
    input  logic                     req_r,
    output logic [WIDTH-1:0]         data_r,
    output logic                     valid_r,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [DEPTH_IN_BITS:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int DEPTH = 2 ** DEPTH_IN_BITS;

    localparam logic [DEPTH_IN_BITS:0]   C_DEPTH   = (DEPTH_IN_BITS+1)'(DEPTH);
    localparam logic [DEPTH_IN_BITS:0]   C_AFULL   = (DEPTH_IN_BITS+1)'(AFULL_LEVEL);
    localparam logic [DEPTH_IN_BITS:0]   C_AEMPTY  = (DEPTH_IN_BITS+1)'(AEMPTY_LEVEL);
    localparam logic [DEPTH_IN_BITS-1:0] C_PTR_INC = DEPTH_IN_BITS'(ONE);
    localparam logic [DEPTH_IN_BITS:0]   C_CNT_INC = (DEPTH_IN_BITS+1)'(ONE);

    // Threshold legality is checked while the design elaborates.
    if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
        $error("fifo_stat: AFULL_LEVEL %0d outside 1..%0d", AFULL_LEVEL, DEPTH);
    end
    if ((AEMPTY_LEVEL < 0) || (AEMPTY_LEVEL > DEPTH - 1)) begin : g_bad_aempty
        $error("fifo_stat: AEMPTY_LEVEL %0d outside 0..%0d", AEMPTY_LEVEL, DEPTH - 1);
    end

    logic [DEPTH_IN_BITS-1:0] r_wr_ptr;
    logic [DEPTH_IN_BITS-1:0] r_rd_ptr;
    logic [DEPTH_IN_BITS:0]   r_count;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic [WIDTH-1:0]         w_rd_data;

    // Flags come straight from the registered count, so full/empty are
    // glitch-free and all DEPTH entries are usable. Reset and clear both
    // suppress acceptance so no pointer or memory side effects leak out.
    always_comb begin
        w_full   = (r_count == C_DEPTH);
        w_empty  = (r_count == '0);
        w_wr_acc = we    && !w_full  && !reset && !clear;
        w_rd_acc = req_r && !w_empty && !reset && !clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= FALSE;
            r_underflow <= FALSE;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= FALSE;
            r_underflow <= FALSE;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_INC;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_INC;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_CNT_INC;
                2'b01:   r_count <= r_count - C_CNT_INC;
                default: r_count <= r_count;
            endcase
            if (we && w_full) begin
                r_overflow <= TRUE;
            end
            if (req_r && w_empty) begin
                r_underflow <= TRUE;
            end
        end
    end

    fifo_ram #(
        .WIDTH         (WIDTH),
        .DEPTH_IN_BITS (DEPTH_IN_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (data_w),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head entry is always presented; valid_r marks the cycle it pops.
        assign data_r  = w_rd_data;
        assign valid_r = w_rd_acc;
    end else begin : g_reg_read
        logic [WIDTH-1:0] r_data_r;
        logic             r_valid_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data_r  <= '0;
                r_valid_r <= FALSE;
            end else if (clear) begin
                // Data register keeps its last popped word across a flush.
                r_valid_r <= FALSE;
            end else begin
                r_valid_r <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data_r <= w_rd_data;
                end
            end
        end

        assign data_r  = r_data_r;
        assign valid_r = r_valid_r;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_stat
`default_nettype wire

// File: doc/fifo_stat.md
FIFO_STAT -- requirements
Module: fifo_stat

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH_IN_BITS, default 4, log2 of storage depth; DEPTH = 2**DEPTH_IN_BITS.
REQ-003 SHALL have parameter AFULL_LEVEL, default 12, almost-full threshold; legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 2, almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through, 0 = registered read with 1-cycle latency.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port clear  input  1  synchronous flush of pointers, count and error flags.
REQ-009 SHALL have port we  input  1  write request.
REQ-010 SHALL have port data_w  input  WIDTH  write data.
REQ-011 SHALL have port req_r  input  1  read request.
REQ-012 SHALL have port data_r  output  WIDTH  read data.
REQ-013 SHALL have port valid_r  output  1  data_r carries a popped word.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port count  output  DEPTH_IN_BITS+1  number of stored words, 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL use all DEPTH entries; full = (count == DEPTH), empty = (count == 0), both derived from registered state.
REQ-018 SHALL accept a write iff we && !full; accepted word stored at write pointer, pointer +1 modulo DEPTH.
REQ-019 SHALL accept a read iff req_r && !empty; read pointer +1 modulo DEPTH.
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged for both or neither.
REQ-021 SHALL, when empty with we and req_r together, accept only the write; the word is readable the next cycle.
REQ-022 SHALL, when full with we and req_r together, accept only the read; the write is dropped and overflow sets.
REQ-023 SHALL, with FWFT=1, drive data_r combinationally from the read-pointer entry and valid_r = read accepted in the same cycle.
REQ-024 SHALL, with FWFT=0, register the popped word into data_r and assert valid_r one cycle after the accepted read, for one cycle; data_r holds its value otherwise.
REQ-025 SHALL drive almost_full = (count >= AFULL_LEVEL) and almost_empty = (count <= AEMPTY_LEVEL).
REQ-026 SHALL set overflow on we && full, and underflow on req_r && empty; both stay set until reset or clear.
REQ-027 SHALL, on clear, zero pointers, count, overflow, underflow and valid_r next cycle; clear overrides we/req_r that cycle; memory contents are retained.
REQ-028 SHALL flag illegal AFULL_LEVEL/AEMPTY_LEVEL at elaboration (simulation error).

Reset
REQ-029 SHALL, on reset, set pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, valid_r=0.
REQ-030 SHALL, with FWFT=0, reset data_r to 0; with FWFT=1, data_r is don't-care while empty.
REQ-031 SHALL give reset priority over clear, we and req_r; reset mid-stream discards all stored words.
REQ-032 SHALL not reset memory contents.

Structure
REQ-033 SHALL take TRUE/FALSE/ONE/ZERO constants from the shared package fifo_pkg.
REQ-034 SHALL instantiate one sub-module fifo_ram: single write port, asynchronous read port, WIDTH x DEPTH.
REQ-035 SHALL keep pointer, count, flag and read-register logic in fifo_stat.

Verification
REQ-036 SHALL cover: DEPTH=16, write 16 words 0..15 -> full=1 at count=16, almost_full from count=12; 17th write -> overflow=1, count stays 16.
REQ-037 SHALL cover: read 16 words, FWFT=1 -> data_r 0..15 in order with valid_r each cycle; FWFT=0 -> same data one cycle later; extra req_r -> underflow=1.
REQ-038 SHALL cover: wrap-around, 40 continuous simultaneous write/read at count=8 -> count stays 8, output order matches input order.
REQ-039 SHALL cover: empty with we and req_r same cycle, data_w=0xA5 -> valid_r=0 that cycle, count=1, 0xA5 popped next read.
REQ-040 SHALL cover: count=5 with overflow=1, pulse clear -> count=0, empty=1, overflow=0 next cycle; then reset during writes -> all reset values of REQ-029.
